// File: rtl/rtc_pkg.sv
// Shared types and defaults for the RTC transaction sequencer.
package rtc_pkg;

  typedef enum logic [1:0] {
    READ_ALL = 2'd0,
    WR_CFG   = 2'd1,
    WR_GRP   = 2'd2,
    WR_ZERO  = 2'd3
  } bus_op_t;

  // Every bus state has an issue phase and a WAIT phase. EDIT and IDLE
  // launch their transaction directly, so they jump straight to a WAIT phase.
  typedef enum logic [3:0] {
    ST_INIT        = 4'd0,
    ST_INIT_WAIT   = 4'd1,
    ST_CFG         = 4'd2,
    ST_CFG_WAIT    = 4'd3,
    ST_RD          = 4'd4,
    ST_RD_WAIT     = 4'd5,
    ST_IDLE        = 4'd6,
    ST_EDIT        = 4'd7,
    ST_COMMIT_WAIT = 4'd8
  } seq_state_t;

  localparam int REFRESH_DEFAULT = 12_500_000;

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running read-back period counter with a sticky pending flag.
module rtc_refresh_timer
  import rtc_pkg::*;
#(
  parameter int REFRESH = REFRESH_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic pending
);

  localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  logic [CW-1:0] count_reg;
  logic          pending_reg;
  logic          wrap;

  assign wrap    = (count_reg == CW'(REFRESH - 1));
  assign pending = pending_reg;

  // A wrap coinciding with a clear keeps the flag set, so no period is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg   <= '0;
      pending_reg <= 1'b0;
    end else begin
      count_reg <= wrap ? '0 : count_reg + 1'b1;
      if (wrap)
        pending_reg <= 1'b1;
      else if (clear)
        pending_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_seq_ctrl.sv
// RTC transaction sequencer: zero-init, periodic read-back, config writes and
// per-group user programming over a start/done handshake with the bus engine.
module rtc_seq_ctrl
  import rtc_pkg::*;
#(
  parameter int NGRP    = 3,
  parameter int CFGW    = 2,
  parameter int REFRESH = REFRESH_DEFAULT,
  parameter int GW      = (NGRP > 1) ? $clog2(NGRP) : 1,
  parameter int SW      = $clog2(NGRP + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NGRP-1:0] prog_req,
  input  logic [CFGW-1:0] cfg_in,
  input  logic            bus_done,
  output logic            bus_start,
  output logic [1:0]      bus_op,
  output logic [GW-1:0]   bus_grp,
  output logic [NGRP-1:0] edit_en,
  output logic            lock,
  output logic [SW-1:0]   disp_sel,
  output logic [CFGW-1:0] cfg_reg,
  output logic            init_done
);

  seq_state_t      state_reg, state_next;
  logic [GW-1:0]   grp_reg, grp_next;
  logic            bus_start_reg, bus_start_next;
  bus_op_t         bus_op_reg, bus_op_next;
  logic [GW-1:0]   bus_grp_reg, bus_grp_next;
  logic [NGRP-1:0] edit_en_reg, edit_en_next;
  logic            lock_reg, lock_next;
  logic [SW-1:0]   disp_sel_reg, disp_sel_next;
  logic [CFGW-1:0] cfg_latch_reg, cfg_latch_next;
  logic            init_done_reg, init_done_next;

  logic            refresh_pending;
  logic            refresh_clear;
  logic [GW-1:0]   req_idx;
  logic [NGRP-1:0] req_onehot;
  logic            launch_cfg;
  logic            launch_rd;

  rtc_refresh_timer #(
    .REFRESH (REFRESH)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (refresh_clear),
    .pending (refresh_pending)
  );

  // Lowest requesting group wins.
  always_comb begin
    req_idx = '0;
    for (int i = NGRP - 1; i >= 0; i--)
      if (prog_req[i])
        req_idx = GW'(i);
  end

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_sel
    assign req_onehot[gi] = (req_idx == GW'(gi));
  end

  always_comb begin
    state_next     = state_reg;
    grp_next       = grp_reg;
    bus_start_next = 1'b0;
    bus_op_next    = bus_op_reg;
    bus_grp_next   = bus_grp_reg;
    edit_en_next   = edit_en_reg;
    lock_next      = lock_reg;
    disp_sel_next  = disp_sel_reg;
    cfg_latch_next = cfg_latch_reg;
    init_done_next = init_done_reg;
    launch_cfg     = 1'b0;
    launch_rd      = 1'b0;

    case (state_reg)
      ST_INIT: begin
        bus_start_next = 1'b1;
        bus_op_next    = WR_ZERO;
        bus_grp_next   = grp_reg;
        state_next     = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (bus_done) begin
          if (grp_reg == GW'(NGRP - 1)) begin
            grp_next   = '0;
            state_next = ST_CFG;
          end else begin
            grp_next   = grp_reg + 1'b1;
            state_next = ST_INIT;
          end
        end
      end
      ST_CFG:      launch_cfg = 1'b1;
      ST_CFG_WAIT: if (bus_done) state_next = ST_RD;
      ST_RD:       launch_rd = 1'b1;
      ST_RD_WAIT: begin
        if (bus_done) begin
          init_done_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cfg_in != cfg_latch_reg) begin
          launch_cfg = 1'b1;
        end else if (|prog_req) begin
          grp_next      = req_idx;
          edit_en_next  = req_onehot;
          lock_next     = 1'b1;
          disp_sel_next = SW'(req_idx) + SW'(1);
          state_next    = ST_EDIT;
        end else if (refresh_pending) begin
          launch_rd = 1'b1;
        end
      end
      ST_EDIT: begin
        // Only the group being edited matters here; everything else waits.
        if (!(|(edit_en_reg & prog_req))) begin
          edit_en_next   = '0;
          bus_start_next = 1'b1;
          bus_op_next    = WR_GRP;
          bus_grp_next   = grp_reg;
          state_next     = ST_COMMIT_WAIT;
        end
      end
      ST_COMMIT_WAIT: begin
        if (bus_done) begin
          lock_next     = 1'b0;
          disp_sel_next = '0;
          state_next    = ST_RD;
        end
      end
      default: state_next = ST_INIT;
    endcase

    if (launch_cfg) begin
      bus_start_next = 1'b1;
      bus_op_next    = WR_CFG;
      bus_grp_next   = '0;
      cfg_latch_next = cfg_in;
      state_next     = ST_CFG_WAIT;
    end
    if (launch_rd) begin
      bus_start_next = 1'b1;
      bus_op_next    = READ_ALL;
      bus_grp_next   = '0;
      state_next     = ST_RD_WAIT;
    end
  end

  assign refresh_clear = bus_start_next && (bus_op_next == READ_ALL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      grp_reg       <= '0;
      bus_start_reg <= 1'b0;
      bus_op_reg    <= READ_ALL;
      bus_grp_reg   <= '0;
      edit_en_reg   <= '0;
      lock_reg      <= 1'b0;
      disp_sel_reg  <= '0;
      cfg_latch_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grp_reg       <= grp_next;
      bus_start_reg <= bus_start_next;
      bus_op_reg    <= bus_op_next;
      bus_grp_reg   <= bus_grp_next;
      edit_en_reg   <= edit_en_next;
      lock_reg      <= lock_next;
      disp_sel_reg  <= disp_sel_next;
      cfg_latch_reg <= cfg_latch_next;
      init_done_reg <= init_done_next;
    end
  end

  assign bus_start = bus_start_reg;
  assign bus_op    = bus_op_reg;
  assign bus_grp   = bus_grp_reg;
  assign edit_en   = edit_en_reg;
  assign lock      = lock_reg;
  assign disp_sel  = disp_sel_reg;
  assign cfg_reg   = cfg_latch_reg;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// Scoreboard bench for rtc_seq_ctrl: directed stimulus, bus engine model, start monitor.
`timescale 1ns/1ps
module tb_rtc_seq_ctrl;

  localparam int NGRP    = 3;
  localparam int CFGW    = 2;
  localparam int REFRESH = 256;
  localparam int GW      = 2;
  localparam int SW      = 2;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_CFG  = 2'd1;
  localparam logic [1:0] OP_GRP  = 2'd2;
  localparam logic [1:0] OP_ZERO = 2'd3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NGRP-1:0] prog_req = '0;
  logic [CFGW-1:0] cfg_in = '0;
  logic            bus_done = 1'b0;
  logic            bus_start;
  logic [1:0]      bus_op;
  logic [GW-1:0]   bus_grp;
  logic [NGRP-1:0] edit_en;
  logic            lock;
  logic [SW-1:0]   disp_sel;
  logic [CFGW-1:0] cfg_reg;
  logic            init_done;

  typedef struct {
    logic [1:0]    op;
    logic [GW-1:0] grp;
    bit            chk_grp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  int   start_count = 0;
  int   last_start_edge = 0;
  int   resp_delay = 3;
  int   spur_cnt = 0;
  int   spur_done = 0;

  always #5 clock = ~clock;

  rtc_seq_ctrl #(
    .NGRP    (NGRP),
    .CFGW    (CFGW),
    .REFRESH (REFRESH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .prog_req  (prog_req),
    .cfg_in    (cfg_in),
    .bus_done  (bus_done),
    .bus_start (bus_start),
    .bus_op    (bus_op),
    .bus_grp   (bus_grp),
    .edit_en   (edit_en),
    .lock      (lock),
    .disp_sel  (disp_sel),
    .cfg_reg   (cfg_reg),
    .init_done (init_done)
  );

  // Edge number since reset release (edge 1 is the first edge after release).
  always @(posedge clock or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every start pops the scoreboard.
  always begin
    @(posedge clock);
    #1;
    if (!reset && bus_start) begin
      start_count++;
      last_start_edge = edge_n;
      $display("[TB] start op=%0d grp=%0d edge=%0d", bus_op, bus_grp, edge_n);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start: op %0d grp %0d, no transaction expected", bus_op, bus_grp);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("start_op", int'(bus_op), int'(e.op));
        if (e.chk_grp) check("start_grp", int'(bus_grp), int'(e.grp));
      end
    end
  end

  // Bus engine model: done resp_delay edges after each start, plus spurious pulses.
  always begin
    @(posedge clock);
    #1;
    if (spur_cnt != spur_done) begin
      spur_done = spur_cnt;
      bus_done = 1'b1;
      @(posedge clock);
      #1;
      bus_done = 1'b0;
    end else if (!reset && bus_start) begin
      int d;
      d = resp_delay;
      if (d > 1) begin
        repeat (d - 1) @(posedge clock);
        #1;
      end
      bus_done = 1'b1;
      @(posedge clock);
      #1;
      bus_done = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic expect_op(input logic [1:0] op, input int grp, input bit chk);
    exp_t e;
    e.op = op;
    e.grp = GW'(grp);
    e.chk_grp = chk;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_start(input string name, input int budget);
    int sc0 = start_count;
    int i = 0;
    while (start_count == sc0 && i < budget) begin
      tick(1);
      i++;
    end
    check(name, start_count - sc0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_start"}, int'(bus_start), 0);
    check({tag, "_bus_op"}, int'(bus_op), 0);
    check({tag, "_bus_grp"}, int'(bus_grp), 0);
    check({tag, "_edit_en"}, int'(edit_en), 0);
    check({tag, "_lock"}, int'(lock), 0);
    check({tag, "_disp_sel"}, int'(disp_sel), 0);
    check({tag, "_cfg_reg"}, int'(cfg_reg), 0);
    check({tag, "_init_done"}, int'(init_done), 0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    repeat (3) @(posedge clock);
    #2;
    exp_q.delete();
    resp_delay = 3;
    reset = 1'b0;
  endtask

  // With 3-cycle responses op k starts at edge 1+4k; READ_ALL done at edge 20.
  task automatic run_init(input int cfg_exp);
    int sc0 = start_count;
    expect_op(OP_ZERO, 0, 1'b1);
    expect_op(OP_ZERO, 1, 1'b1);
    expect_op(OP_ZERO, 2, 1'b1);
    expect_op(OP_CFG, 0, 1'b0);
    expect_op(OP_RD, 0, 1'b0);
    tick(1);
    check("first_start_count", start_count - sc0, 1);
    check("first_start_edge", last_start_edge, 1);
    tick(18);
    check("init_done_before", int'(init_done), 0);
    tick(1);
    check("init_done_after", int'(init_done), 1);
    wait_drain("init_drain", 5);
    check("init_cfg_reg", int'(cfg_reg), cfg_exp);
  endtask

  initial begin
    int sc;
    // Reset values and the initialisation sequence.
    #2;
    do_reset("rst0");
    run_init(0);

    // Spurious done in IDLE.
    sc = start_count;
    spur_cnt++;
    tick(6);
    check("spur_no_start", start_count - sc, 0);
    check("spur_lock", int'(lock), 0);
    check("spur_edit_en", int'(edit_en), 0);
    check("spur_disp_sel", int'(disp_sel), 0);

    // Programming request 110: group 1 first, group 2 deferred.
    prog_req = 3'b110;
    tick(1);
    check("edit1_edit_en", int'(edit_en), 2);
    check("edit1_disp_sel", int'(disp_sel), 2);
    check("edit1_lock", int'(lock), 1);
    sc = start_count;
    tick(4);
    check("edit1_hold_no_start", start_count - sc, 0);
    check("edit1_hold_edit_en", int'(edit_en), 2);
    expect_op(OP_GRP, 1, 1'b1);
    expect_op(OP_RD, 0, 1'b0);
    prog_req = 3'b100;
    tick(1);
    check("commit1_edit_en", int'(edit_en), 0);
    check("commit1_lock", int'(lock), 1);
    tick(3);
    check("commit1_done_lock", int'(lock), 0);
    check("commit1_done_disp_sel", int'(disp_sel), 0);
    tick(5);
    check("edit2_edit_en", int'(edit_en), 4);
    check("edit2_disp_sel", int'(disp_sel), 3);
    check("edit2_lock", int'(lock), 1);
    wait_drain("edit1_drain", 5);
    expect_op(OP_GRP, 2, 1'b1);
    expect_op(OP_RD, 0, 1'b0);
    prog_req = 3'b000;
    wait_drain("edit2_drain", 20);
    tick(4);

    // Configuration change during EDIT is deferred until after the commit.
    do_reset("rst1");
    run_init(0);
    prog_req = 3'b001;
    tick(1);
    check("edit0_edit_en", int'(edit_en), 1);
    cfg_in = 2'b01;
    sc = start_count;
    tick(6);
    check("edit0_cfg_deferred", start_count - sc, 0);
    check("edit0_cfg_reg_held", int'(cfg_reg), 0);
    expect_op(OP_GRP, 0, 1'b1);
    expect_op(OP_RD, 0, 1'b0);
    expect_op(OP_CFG, 0, 1'b0);
    expect_op(OP_RD, 0, 1'b0);
    prog_req = 3'b000;
    wait_drain("cfg_defer_drain", 40);
    tick(4);
    check("cfg_defer_cfg_reg", int'(cfg_reg), 1);
    check("cfg_defer_lock", int'(lock), 0);

    // Simultaneous cfg change and request: CFG and RD first, then EDIT.
    expect_op(OP_CFG, 0, 1'b0);
    expect_op(OP_RD, 0, 1'b0);
    cfg_in = 2'b10;
    prog_req = 3'b010;
    tick(1);
    check("simul_edit_deferred", int'(edit_en), 0);
    wait_drain("simul_drain", 20);
    tick(4);
    check("simul_edit_en", int'(edit_en), 2);
    check("simul_cfg_reg", int'(cfg_reg), 2);
    expect_op(OP_GRP, 1, 1'b1);
    expect_op(OP_RD, 0, 1'b0);
    prog_req = 3'b000;
    wait_drain("simul_commit_drain", 20);
    tick(4);

    // Reset two cycles into a WR_GRP, then the sequence restarts.
    cfg_in = 2'b11;
    do_reset("rst2");
    run_init(3);
    prog_req = 3'b100;
    tick(1);
    expect_op(OP_GRP, 2, 1'b1);
    prog_req = 3'b000;
    tick(1);
    tick(2);
    check("midgrp_lock", int'(lock), 1);
    check("midgrp_bus_op", int'(bus_op), 2);
    do_reset("rst_mid");
    run_init(3);

    // Refresh: first wrap at edge 256 -> READ_ALL at 257, held past wraps at
    // 512 and 768, done at 770 -> exactly one READ_ALL at 771, none until 1024.
    resp_delay = 513;
    expect_op(OP_RD, 0, 1'b0);
    wait_start("refresh_first_start", 300);
    check("refresh_first_edge", last_start_edge, REFRESH + 1);
    resp_delay = 2;
    expect_op(OP_RD, 0, 1'b0);
    wait_start("refresh_pending_start", 600);
    check("refresh_pending_edge", last_start_edge, 3 * REFRESH + 3);
    sc = start_count;
    tick(4 * REFRESH - 4 - edge_n);
    check("refresh_collapsed", start_count - sc, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_seq_ctrl.md
# rtc_seq_ctrl

Parametrised transaction sequencer for the RTC subsystem, successor to the fixed-count control FSM. It sequences zero-initialisation, periodic read-back, configuration writes and user programming for `NGRP` register groups (default: hour, date, chronometer). Bus transactions use a start/done handshake with the RTC bus engine instead of fixed cycle slots. It sits between the user-input/debounce logic and the RTC bus engine, and drives the display data mux.

## Interface
- `NGRP`, 3, number of programmable register groups (≥1)
- `CFGW`, 2, width of the configuration word (bit0 format 12/24 h, bit1 chrono run)
- `REFRESH`, 12_500_000, period in clock cycles of the automatic read-back (≥4)
- `GW`, derived `$clog2(NGRP)` (min 1), group index width
- `SW`, derived `$clog2(NGRP+1)`, display select width

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `prog_req`  in  NGRP  level, user requests programming of group g
- `cfg_in`  in  CFGW  level, requested configuration
- `bus_done`  in  1  one-cycle pulse, bus engine finished current transaction
- `bus_start`  out  1  one-cycle pulse, launch transaction
- `bus_op`  out  2  0 READ_ALL, 1 WR_CFG, 2 WR_GRP, 3 WR_ZERO
- `bus_grp`  out  GW  target group for WR_GRP/WR_ZERO
- `edit_en`  out  NGRP  one-hot, enables the edit counters of group g
- `lock`  out  1  high while a group is being edited or committed
- `disp_sel`  out  SW  0 = live RTC data, g+1 = edit registers of group g
- `cfg_reg`  out  CFGW  configuration last written to RTC
- `init_done`  out  1  high once initial zero-write and first read completed

## Operation
- States: INIT, RD, IDLE, CFG, EDIT, COMMIT, plus a WAIT sub-phase for every bus state.
- Bus state entry: `bus_start`=1 for exactly one cycle with `bus_op`/`bus_grp` valid. `bus_op`/`bus_grp` then stay stable until `bus_done` is sampled. The FSM then leaves WAIT.
- INIT: WR_ZERO for groups 0..NGRP-1 in ascending order, then WR_CFG with `cfg_in` (latched into `cfg_reg`), then RD. `init_done` sets on RD completion.
- RD: READ_ALL, then IDLE. A pending refresh is cleared at `bus_start`.
- IDLE priority, evaluated each cycle (highest first):
  1. `cfg_in != cfg_reg` → CFG (WR_CFG, latch `cfg_reg`), then RD.
  2. Any `prog_req` bit set → EDIT for the lowest set index g: `edit_en[g]`=1, `disp_sel`=g+1, `lock`=1.
  3. Refresh pending → RD.
- EDIT: stay while `prog_req[g]`=1. Other `prog_req` bits, cfg changes and refresh are ignored (deferred). On `prog_req[g]`=0: `edit_en`=0, go to COMMIT (WR_GRP, `bus_grp`=g). On done: `lock`=0, `disp_sel`=0, go to RD.
- Refresh timer: free-running 0..REFRESH-1. At wrap it sets refresh-pending, which is sticky until serviced. Multiple wraps collapse into one pending request.
- `bus_done` outside WAIT is ignored.

## Timing
- Reset values: every output 0; state INIT; timer 0; refresh-pending 0. The first `bus_start` (WR_ZERO, group 0) occurs on the first clock edge after reset release.
- All outputs are registered. A condition sampled at edge k is reflected on outputs after edge k.
- `bus_done` sampled at edge k: the next `bus_start` (if any) is high after edge k+1, giving one IDLE/decision cycle.
- prog_req rise → `edit_en` high: 1 edge from IDLE. prog_req fall → `bus_start` (WR_GRP): 1 edge.
- Reset asserted mid-transaction: outputs clear immediately (async), and INIT restarts. The bus engine must abort on reset.
- Simultaneous cfg change and prog_req in IDLE: CFG first, then EDIT after RD.

## Structure
- Package `rtc_pkg`: `bus_op_t` enum (READ_ALL, WR_CFG, WR_GRP, WR_ZERO), `seq_state_t` enum, default `REFRESH` constant.
- Sub-module `rtc_refresh_timer` (parameter `REFRESH`): counter plus sticky pending flag with a clear input.
- Top FSM with the priority decode in a single combinational next-state block.

## Test plan
- Reset release, `bus_done` returned 3 cycles after each start, NGRP=3 → ops WR_ZERO g0, g1, g2, WR_CFG, READ_ALL; `init_done`=1 after the fifth done.
- IDLE, `prog_req`=3'b110 → `edit_en`=3'b010, `disp_sel`=2, `lock`=1. Drop bit1 → WR_GRP `bus_grp`=1, then READ_ALL, then `lock`=0.
- During EDIT, toggle `cfg_in` 00→01 → no `bus_start` until commit. After COMMIT's READ_ALL, WR_CFG with `cfg_reg`=01, then READ_ALL.
- REFRESH=8, bus held busy 20 cycles → exactly one READ_ALL issued after return to IDLE.
- Assert `reset` 2 cycles after a WR_GRP start → all outputs 0 asynchronously. After release, the sequence restarts with WR_ZERO g0.
- Spurious `bus_done` in IDLE → no state change, no `bus_start`.
